inference_sequencer: RTL and testbench
======================================

# inference_sequencer

Control FSM that sequences one inference pass through the accelerator datapath: weight preload into the systolic array, input row streaming, output drain to the output buffer, then a completion pulse. It sits between the AHB register block, which supplies `start`, `abort` and the configuration, and the datapath (weight/input/output buffers plus the array). It issues buffer addresses and array strobes only; it never touches data.

## Interface
Parameters:
- `ARRAY_DIM`, 8: array rows; the number of weight rows loaded per pass.
- `ADDR_W`, 6: buffer address width.
- `DRAIN_LAT`, 15: watchdog limit, in idle cycles, while waiting for array outputs.

Ports:
- `clk`  in  1  system clock. All logic is on the rising edge.
- `n_rst`  in  1  synchronous reset, active-low. It is sampled on the rising edge of `clk`.
- `start`  in  1  one-cycle go pulse from the register block.
- `abort`  in  1  returns the block to IDLE from any state.
- `cfg_num_rows`  in  ADDR_W  input rows this pass; legal range 1..2^ADDR_W-1.
- `arr_out_valid`  in  1  the array presents one output row this cycle.
- `wbuf_ren`, `wbuf_raddr`  out  1, ADDR_W  weight buffer read request and address. Read latency is 1 cycle.
- `ibuf_ren`, `ibuf_raddr`  out  1, ADDR_W  input buffer read request and address. Read latency is 1 cycle.
- `arr_wload`  out  1  weight data on the array input is valid; the array shifts it in.
- `arr_in_valid`  out  1  input row data on the array input is valid.
- `obuf_wen`, `obuf_waddr`  out  1, ADDR_W  output buffer write strobe and address.
- `busy`  out  1  a pass is in progress.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  sticky error flag.

## Operation
- States: IDLE, LOAD_W, STREAM, DRAIN, DONE, ERR.
- IDLE:
  - `start` with `cfg_num_rows`≠0 latches N=`cfg_num_rows`, clears `err` and all counters, and moves to LOAD_W.
  - `start` with N=0 moves to ERR.
- LOAD_W: `wbuf_ren`=1 with `wbuf_raddr`=0..ARRAY_DIM-1 on consecutive cycles. After the last address, the state moves to STREAM.
- STREAM: `ibuf_ren`=1 with `ibuf_raddr`=0..N-1 on consecutive cycles. After the last address, the state moves to DRAIN.
- DRAIN: waits until the output count reaches N, then moves to DONE.
  - The watchdog counts consecutive DRAIN cycles with `arr_out_valid`=0.
  - The watchdog clears on every `arr_out_valid`.
  - When the watchdog reaches DRAIN_LAT, the state moves to ERR.
- DONE: `done`=1 for exactly one cycle, then IDLE.
- ERR: `err`=1. The state moves to IDLE on the next cycle; `err` stays high until the next accepted `start`.
- `arr_wload` and `arr_in_valid` are `wbuf_ren` and `ibuf_ren` delayed by one register stage. This aligns them with the buffer read data.
- Output capture:
  - In STREAM or DRAIN, every `arr_out_valid` cycle registers `obuf_wen`=1 on the following cycle.
  - `obuf_waddr` equals the output count, which then increments.
  - `arr_out_valid` in any other state is ignored.
  - Outputs beyond N are ignored: no write, no count.
- `start` while `busy`=1 is ignored.
- `abort` has priority over `start` and over every transition:
  - Next state is IDLE.
  - All strobes deassert on the next cycle, and the delayed strobe registers are cleared.
  - `done` is not pulsed.
  - `err` is unchanged.
- `busy`=1 in LOAD_W, STREAM, DRAIN and DONE. `busy`=0 in IDLE and ERR.
- Counters are ADDR_W+1 bits wide, so a count of N=2^ADDR_W-1 never wraps. Addresses are the low ADDR_W bits.

## Timing
- Reset (`n_rst`=0 at an edge): state is IDLE and every output is 0, including `err`. Reset mid-pass aborts without `done`.
- The notation below uses D=ARRAY_DIM; cycle k means the k-th edge after the edge that sampled `start`.
  - Cycles 1..D: LOAD_W, `wbuf_raddr`=k-1.
  - Cycles 2..D+1: `arr_wload`=1.
  - Cycles D+1..D+N: STREAM, `ibuf_raddr`=k-D-1.
  - Cycles D+2..D+N+1: `arr_in_valid`=1.
  - From cycle D+N+1: DRAIN.
- `arr_wload` and `ibuf_ren` are both high at cycle D+1. This overlap is legal.
- `obuf_wen` follows `arr_out_valid` by exactly 1 cycle.
- `done` rises 1 cycle after the DRAIN edge at which the output count equals N. When the N-th `arr_out_valid` arrives in STREAM, DONE follows DRAIN after one cycle.
- `busy` rises the cycle after `start` and falls the cycle after `done`.

## Test plan
- **Normal pass.** D=8, N=4; the model returns `arr_out_valid` 5 cycles after each `arr_in_valid`.
  - Required: `wbuf_raddr` 0..7, `ibuf_raddr` 0..3, `obuf_waddr` 0..3.
  - Required: one `done` pulse, `err`=0, `busy` low after `done`.
- **Zero rows.** `start` with N=0 → `err`=1 the next cycle, `busy` never asserts, no buffer strobes. A following `start` with N=2 clears `err`.
- **Watchdog.** N=3, only 2 `arr_out_valid` returned → ERR after 15 idle DRAIN cycles, `err` sticky, no `done`.
- **Abort.** `abort` at cycle 3 of STREAM → IDLE the next cycle, all strobes 0 within 1 cycle, no `done`, and a fresh `start` runs a normal pass.
- **Start while busy; excess outputs.** `start` pulsed in LOAD_W is ignored and the address sequence is unchanged. A 5th `arr_out_valid` on N=4 produces no write.
- **Maximum N and reset.** N=63 → final `obuf_waddr`=62, then `done`. A second run with `n_rst` low mid-DRAIN → all outputs 0 and no `done`.

Source files
------------

// File: rtl/inference_sequencer.sv
// rtl/inference_sequencer.sv - sequences one inference pass: weight preload, input streaming, output drain
// Issues buffer read/write addresses and array strobes; never touches data.
module inference_sequencer #(
   parameter int ARRAY_DIM = 8,
   parameter int ADDR_W    = 6,
   parameter int DRAIN_LAT = 15
) (
   input  logic              clk,
   input  logic              n_rst,
   input  logic              start,
   input  logic              abort,
   input  logic [ADDR_W-1:0] cfg_num_rows,
   input  logic              arr_out_valid,
   output logic              wbuf_ren,
   output logic [ADDR_W-1:0] wbuf_raddr,
   output logic              ibuf_ren,
   output logic [ADDR_W-1:0] ibuf_raddr,
   output logic              arr_wload,
   output logic              arr_in_valid,
   output logic              obuf_wen,
   output logic [ADDR_W-1:0] obuf_waddr,
   output logic              busy,
   output logic              done,
   output logic              err
);
   // One extra counter bit so N = 2^ADDR_W-1 outputs can be counted without wrapping.
   localparam int CW = ADDR_W + 1;
   localparam int WW = $clog2(DRAIN_LAT + 1);
   localparam logic [CW-1:0] ONE     = CW'(1);
   localparam logic [CW-1:0] W_LAST  = CW'(ARRAY_DIM - 1);
   localparam logic [WW-1:0] WD_LAST = WW'(DRAIN_LAT - 1);

   typedef enum logic [2:0] {IDLE, LOAD_W, STREAM, DRAIN, DONE, ERR} state_t;

   state_t        state;
   logic [CW-1:0] num_rows;
   logic [CW-1:0] rd_cnt;
   logic [CW-1:0] out_cnt;
   logic [WW-1:0] wdog;
   logic [CW-1:0] rd_next;
   logic [CW-1:0] last_row;
   logic          capture;

   always_comb begin
      rd_next  = rd_cnt + ONE;
      last_row = num_rows - ONE;
      capture  = (state == STREAM || state == DRAIN) && arr_out_valid && (out_cnt < num_rows);
   end

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         state        <= IDLE;
         num_rows     <= '0;
         rd_cnt       <= '0;
         out_cnt      <= '0;
         wdog         <= '0;
         wbuf_ren     <= 1'b0;
         wbuf_raddr   <= '0;
         ibuf_ren     <= 1'b0;
         ibuf_raddr   <= '0;
         arr_wload    <= 1'b0;
         arr_in_valid <= 1'b0;
         obuf_wen     <= 1'b0;
         obuf_waddr   <= '0;
         busy         <= 1'b0;
         done         <= 1'b0;
         err          <= 1'b0;
      end else if (abort) begin
         // err is deliberately left as-is so a prior fault stays visible.
         state        <= IDLE;
         wbuf_ren     <= 1'b0;
         ibuf_ren     <= 1'b0;
         arr_wload    <= 1'b0;
         arr_in_valid <= 1'b0;
         obuf_wen     <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
      end else begin
         arr_wload    <= wbuf_ren;
         arr_in_valid <= ibuf_ren;
         obuf_wen     <= capture;
         done         <= 1'b0;
         if (capture) begin
            obuf_waddr <= out_cnt[ADDR_W-1:0];
            out_cnt    <= out_cnt + ONE;
         end
         case (state)
            IDLE: begin
               if (start) begin
                  if (cfg_num_rows != '0) begin
                     state      <= LOAD_W;
                     num_rows   <= {1'b0, cfg_num_rows};
                     err        <= 1'b0;
                     rd_cnt     <= '0;
                     out_cnt    <= '0;
                     wdog       <= '0;
                     wbuf_ren   <= 1'b1;
                     wbuf_raddr <= '0;
                     busy       <= 1'b1;
                  end else begin
                     state <= ERR;
                     err   <= 1'b1;
                  end
               end
            end
            LOAD_W: begin
               if (rd_cnt == W_LAST) begin
                  state      <= STREAM;
                  wbuf_ren   <= 1'b0;
                  ibuf_ren   <= 1'b1;
                  ibuf_raddr <= '0;
                  rd_cnt     <= '0;
               end else begin
                  rd_cnt     <= rd_next;
                  wbuf_raddr <= rd_next[ADDR_W-1:0];
               end
            end
            STREAM: begin
               if (rd_cnt == last_row) begin
                  state    <= DRAIN;
                  ibuf_ren <= 1'b0;
                  wdog     <= '0;
               end else begin
                  rd_cnt     <= rd_next;
                  ibuf_raddr <= rd_next[ADDR_W-1:0];
               end
            end
            DRAIN: begin
               // Completion wins over the watchdog; any output row restarts the idle count.
               if (out_cnt == num_rows) begin
                  state <= DONE;
                  done  <= 1'b1;
               end else if (arr_out_valid) begin
                  wdog <= '0;
               end else if (wdog == WD_LAST) begin
                  state <= ERR;
                  err   <= 1'b1;
                  busy  <= 1'b0;
               end else begin
                  wdog <= wdog + WW'(1);
               end
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            ERR: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_inference_sequencer.sv
// tb/tb_inference_sequencer.sv - table-driven, hand-written and randomized checks of inference_sequencer
// Expected traces come from a per-pass cycle model built from the pass timing rules.
module tb_inference_sequencer;
   localparam int D    = 8;
   localparam int AW   = 6;
   localparam int DL   = 15;
   localparam int MAXL = 1400;

   typedef struct {
      int n;
      int vstart;
      int vcount;
      int abort_c;
      int xstart_c;
      int exp_done;
      int exp_err;
      int exp_writes;
   } vec_t;

   logic          clk = 1'b0;
   logic          n_rst = 1'b0;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic          arr_out_valid = 1'b0;
   logic [AW-1:0] cfg_num_rows = '0;
   logic          wbuf_ren, ibuf_ren, arr_wload, arr_in_valid, obuf_wen, busy, done, err;
   logic [AW-1:0] wbuf_raddr, ibuf_raddr, obuf_waddr;

   int checks = 0;
   int failures = 0;

   int v_in    [MAXL+2];
   int e_wren  [MAXL+2];
   int e_waddr [MAXL+2];
   int e_iren  [MAXL+2];
   int e_iaddr [MAXL+2];
   int e_wload [MAXL+2];
   int e_ivld  [MAXL+2];
   int e_owen  [MAXL+2];
   int e_oaddr [MAXL+2];
   int e_busy  [MAXL+2];
   int e_done  [MAXL+2];
   int e_err   [MAXL+2];

   always #5 clk = ~clk;

   inference_sequencer #(.ARRAY_DIM(D), .ADDR_W(AW), .DRAIN_LAT(DL)) dut (
      .clk          (clk),
      .n_rst        (n_rst),
      .start        (start),
      .abort        (abort),
      .cfg_num_rows (cfg_num_rows),
      .arr_out_valid(arr_out_valid),
      .wbuf_ren     (wbuf_ren),
      .wbuf_raddr   (wbuf_raddr),
      .ibuf_ren     (ibuf_ren),
      .ibuf_raddr   (ibuf_raddr),
      .arr_wload    (arr_wload),
      .arr_in_valid (arr_in_valid),
      .obuf_wen     (obuf_wen),
      .obuf_waddr   (obuf_waddr),
      .busy         (busy),
      .done         (done),
      .err          (err)
   );

   task automatic chk(input string name, input int j, input logic [31:0] act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at %0d: got %0d, need %0d", name, j, act, exp);
      end
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_wbuf_ren"}, 0, 32'(wbuf_ren), 0);
      chk({tag, "_wbuf_raddr"}, 0, 32'(wbuf_raddr), 0);
      chk({tag, "_ibuf_ren"}, 0, 32'(ibuf_ren), 0);
      chk({tag, "_ibuf_raddr"}, 0, 32'(ibuf_raddr), 0);
      chk({tag, "_arr_wload"}, 0, 32'(arr_wload), 0);
      chk({tag, "_arr_in_valid"}, 0, 32'(arr_in_valid), 0);
      chk({tag, "_obuf_wen"}, 0, 32'(obuf_wen), 0);
      chk({tag, "_obuf_waddr"}, 0, 32'(obuf_waddr), 0);
      chk({tag, "_busy"}, 0, 32'(busy), 0);
      chk({tag, "_done"}, 0, 32'(done), 0);
      chk({tag, "_err"}, 0, 32'(err), 0);
   endtask

   task automatic set_valids(input int vs, input int vc);
      for (int j = 0; j < MAXL + 2; j++)
         v_in[j] = (vs > 0 && j >= vs && j < vs + vc) ? 1 : 0;
   endtask

   task automatic set_rand_valids(input int odds);
      for (int j = 0; j < MAXL + 2; j++)
         v_in[j] = ($urandom_range(odds - 1, 0) == 0) ? 1 : 0;
   endtask

   // Cycle k is the k-th cycle after the edge that samples start; v_in[k] is sampled at its closing edge.
   task automatic build_model(input int n, input int ac, output int last);
      int cnt, run, end_c, is_err;
      for (int j = 0; j < MAXL + 2; j++) begin
         e_wren[j] = 0; e_waddr[j] = 0; e_iren[j] = 0; e_iaddr[j] = 0;
         e_wload[j] = 0; e_ivld[j] = 0; e_owen[j] = 0; e_oaddr[j] = 0;
         e_busy[j] = 0; e_done[j] = 0; e_err[j] = 0;
      end
      cnt = 0;
      run = 0;
      is_err = (n == 0) ? 1 : 0;
      end_c = (n == 0) ? 1 : 0;
      for (int j = 1; j <= MAXL; j++) begin
         if (n != 0) begin
            e_wren[j]  = (j <= D) ? 1 : 0;
            e_waddr[j] = j - 1;
            e_wload[j] = (j >= 2 && j <= D + 1) ? 1 : 0;
            e_iren[j]  = (j >= D + 1 && j <= D + n) ? 1 : 0;
            e_iaddr[j] = j - D - 1;
            e_ivld[j]  = (j >= D + 2 && j <= D + n + 1) ? 1 : 0;
         end
         if (end_c == 0) begin
            e_busy[j] = 1;
            if (j >= D + n + 1) begin
               if (cnt == n) end_c = j + 1;
               else if (v_in[j] != 0) run = 0;
               else begin
                  run++;
                  if (run == DL) begin
                     end_c = j + 1;
                     is_err = 1;
                  end
               end
            end
            if (j >= D + 1 && v_in[j] != 0 && cnt < n) begin
               e_owen[j + 1]  = 1;
               e_oaddr[j + 1] = cnt;
               cnt++;
            end
         end else if (j == end_c) begin
            e_busy[j] = 1 - is_err;
            e_done[j] = 1 - is_err;
         end
         e_err[j] = (is_err != 0 && end_c != 0 && j >= end_c) ? 1 : 0;
      end
      last = (end_c == 0) ? MAXL : end_c + 3;
      if (ac != 0 && ac + 3 < last) last = ac + 3;
      if (last > MAXL) last = MAXL;
      if (ac != 0) begin
         for (int j = ac + 1; j <= MAXL; j++) begin
            e_wren[j] = 0; e_iren[j] = 0; e_wload[j] = 0; e_ivld[j] = 0;
            e_owen[j] = 0; e_busy[j] = 0; e_done[j] = 0; e_err[j] = e_err[ac];
         end
      end
   endtask

   task automatic run_pass(input int n, input int ac, input int xs,
                           output int n_done, output int n_wr, output int last_err);
      int last;
      build_model(n, ac, last);
      n_done = 0;
      n_wr = 0;
      @(negedge clk);
      start = 1'b1;
      cfg_num_rows = AW'(n);
      for (int j = 1; j <= last; j++) begin
         @(negedge clk);
         chk("wbuf_ren", j, 32'(wbuf_ren), e_wren[j]);
         if (e_wren[j] != 0) chk("wbuf_raddr", j, 32'(wbuf_raddr), e_waddr[j]);
         chk("ibuf_ren", j, 32'(ibuf_ren), e_iren[j]);
         if (e_iren[j] != 0) chk("ibuf_raddr", j, 32'(ibuf_raddr), e_iaddr[j]);
         chk("arr_wload", j, 32'(arr_wload), e_wload[j]);
         chk("arr_in_valid", j, 32'(arr_in_valid), e_ivld[j]);
         chk("obuf_wen", j, 32'(obuf_wen), e_owen[j]);
         if (e_owen[j] != 0) chk("obuf_waddr", j, 32'(obuf_waddr), e_oaddr[j]);
         chk("busy", j, 32'(busy), e_busy[j]);
         chk("done", j, 32'(done), e_done[j]);
         chk("err", j, 32'(err), e_err[j]);
         n_done += int'(done);
         n_wr += int'(obuf_wen);
         start = (j == xs && j < last);
         abort = (j == ac && j < last);
         arr_out_valid = (j < last && v_in[j] != 0);
         cfg_num_rows = AW'($urandom);
      end
      last_err = int'(err);
      start = 1'b0;
      abort = 1'b0;
      arr_out_valid = 1'b0;
   endtask

   initial begin
      #3000000;
      $display("FAIL timeout: simulation time bound reached");
      $fatal(1, "timeout");
   end

   initial begin
      vec_t vecs [10];
      int nd, nw, fe, ac, xs, n;
      vecs[0] = '{4, 15, 4, 0, 0, 1, 0, 4};
      vecs[1] = '{0, 0, 0, 0, 0, 0, 1, 0};
      vecs[2] = '{2, 15, 2, 0, 0, 1, 0, 2};
      vecs[3] = '{3, 15, 2, 0, 0, 0, 1, 2};
      vecs[4] = '{4, 15, 4, D + 3, 0, 0, 0, 0};
      vecs[5] = '{4, 15, 4, 0, 0, 1, 0, 4};
      vecs[6] = '{4, 15, 4, 0, 3, 1, 0, 4};
      vecs[7] = '{4, 15, 5, 0, 0, 1, 0, 4};
      vecs[8] = '{4, D + 1, 4, 0, 0, 1, 0, 4};
      vecs[9] = '{63, 15, 63, 0, 0, 1, 0, 63};

      n_rst = 1'b0;
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      n_rst = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 10; i++) begin
         set_valids(vecs[i].vstart, vecs[i].vcount);
         run_pass(vecs[i].n, vecs[i].abort_c, vecs[i].xstart_c, nd, nw, fe);
         chk($sformatf("vec%0d_done_count", i), i, 32'(nd), vecs[i].exp_done);
         chk($sformatf("vec%0d_err_final", i), i, 32'(fe), vecs[i].exp_err);
         chk($sformatf("vec%0d_writes", i), i, 32'(nw), vecs[i].exp_writes);
      end

      for (int i = 0; i < 12; i++) begin
         n = int'($urandom_range(20, 1));
         set_rand_valids(int'($urandom_range(6, 2)));
         ac = ($urandom_range(3, 0) == 0) ? int'($urandom_range(D + n + 10, 1)) : 0;
         xs = (ac == 0 && $urandom_range(1, 0) == 1) ? int'($urandom_range(D + n, 1)) : 0;
         run_pass(n, ac, xs, nd, nw, fe);
      end

      // Reset in the middle of DRAIN: everything clears and no done follows.
      set_valids(0, 0);
      @(negedge clk);
      start = 1'b1;
      cfg_num_rows = AW'(4);
      repeat (D + 7) begin
         @(negedge clk);
         start = 1'b0;
      end
      chk("busy_in_drain", 0, 32'(busy), 1);
      n_rst = 1'b0;
      @(negedge clk);
      check_all_zero("mid_drain_reset");
      n_rst = 1'b1;
      for (int j = 1; j <= 30; j++) begin
         @(negedge clk);
         chk("done_after_reset", j, 32'(done), 0);
         chk("busy_after_reset", j, 32'(busy), 0);
      end

      // Reset also clears a sticky err.
      run_pass(0, 0, 0, nd, nw, fe);
      chk("zero_rows_err", 0, 32'(fe), 1);
      n_rst = 1'b0;
      @(negedge clk);
      check_all_zero("reset_clears_err");
      n_rst = 1'b1;
      @(negedge clk);

      set_valids(15, 4);
      run_pass(4, 0, 0, nd, nw, fe);
      chk("recovery_done_count", 0, 32'(nd), 1);
      chk("recovery_writes", 0, 32'(nw), 4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
